char_mem_arbiter: RTL

Arbiter for the shared single-port character/font memory, sitting between the video pixel pipeline, the CPU bus, and one synchronous BRAM port. Video fetches own the port unconditionally. CPU reads are scheduled into free cycles and stall the processor only until a slot opens. CPU byte writes are absorbed by a one-entry write buffer and drained in free cycles, so stores normally cost no CPU wait. It replaces the coarse "stall while xpos[2:1]==0" rule with cycle-exact slot arbitration.

---
 rtl/char_mem_pkg.sv | 19 +
 rtl/char_wbuf.sv | 55 +++++
 rtl/char_mem_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/char_mem_pkg.sv
// Shared constants and types for the character/font memory arbiter.
// The read FSM state type lives here so the arbiter and any neighbours agree on it.
package char_mem_pkg;

    localparam int unsigned ADDR_WIDTH = 13;
    localparam int unsigned FONT_BASE  = 2560;
    localparam int unsigned CHAR_DEPTH = 4096;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StData = 2'd2
    } rd_state_e;

    function automatic logic [31:0] replicate_byte(input logic [7:0] b);
        return {4{b}};
    endfunction

endpackage

// File: rtl/char_wbuf.sv
// One-entry CPU write buffer: holds a byte store until the arbiter finds a free slot.
// A load in the same cycle as a drain wins, since the old entry leaves on that edge.
module char_wbuf
    import char_mem_pkg::*;
#(
    parameter int unsigned AddrWidth = ADDR_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 load_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [7:0]           data_i,
    input  logic                 drain_i,
    input  logic [AddrWidth-1:0] match_addr_i,
    output logic                 valid_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [7:0]           data_o,
    output logic                 hit_o
);

    logic                 valid_q, valid_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [7:0]           data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign hit_o   = valid_q && (addr_q == match_addr_i);

endmodule

// File: rtl/char_mem_arbiter.sv
// Shared-port arbiter for the character/font BRAM: video always owns the port, CPU reads
// take the next free slot, and CPU byte writes are buffered and drained in idle slots.
module char_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  vid_req_i,
    input  logic [ADDR_WIDTH-1:0] vid_addr_i,
    output logic [7:0]            vid_rdata_o,
    input  logic                  cpu_rstrb_i,
    input  logic                  cpu_wstrb_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [7:0]            cpu_wdata_i,
    output logic [31:0]           cpu_rdata_o,
    output logic                  cpu_rbusy_o,
    output logic                  cpu_wbusy_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [7:0]            mem_wdata_o,
    input  logic [7:0]            mem_rdata_i
);
    import char_mem_pkg::*;

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_fwd_q, rd_fwd_d;
    logic [7:0]            rd_fwd_data_q, rd_fwd_data_d;
    logic [7:0]            cpu_hold_q, cpu_hold_d;
    logic                  vid_req_q;
    logic [7:0]            vid_hold_q;

    logic [ADDR_WIDTH-1:0] rd_cur_addr;
    logic [7:0]            rd_byte;
    logic [7:0]            vid_byte;
    logic                  rd_try;
    logic                  rd_active;
    logic                  rd_port;

    logic                  wb_valid;
    logic                  wb_hit;
    logic                  wb_load;
    logic                  drain;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [7:0]            wb_data;

    // A waiting read compares its latched address; a fresh strobe compares the bus address.
    assign rd_cur_addr = (state_q == StWait) ? rd_addr_q : cpu_addr_i;
    assign rd_byte     = rd_fwd_q ? rd_fwd_data_q : mem_rdata_i;

    char_wbuf #(
        .AddrWidth (ADDR_WIDTH)
    ) u_wbuf (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .load_i       (wb_load),
        .addr_i       (cpu_addr_i),
        .data_i       (cpu_wdata_i),
        .drain_i      (drain),
        .match_addr_i (rd_cur_addr),
        .valid_o      (wb_valid),
        .addr_o       (wb_addr),
        .data_o       (wb_data),
        .hit_o        (wb_hit)
    );

    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        rd_fwd_d      = rd_fwd_q;
        rd_fwd_data_d = rd_fwd_data_q;
        cpu_hold_d    = cpu_hold_q;
        rd_try        = 1'b0;
        rd_active     = 1'b0;
        rd_port       = 1'b0;

        if (state_q == StData) begin
            cpu_hold_d = rd_byte;
        end

        unique case (state_q)
            StIdle, StData: begin
                state_d = StIdle;
                if (cpu_rstrb_i) begin
                    rd_addr_d = cpu_addr_i;
                    rd_try    = 1'b1;
                end
            end
            StWait: rd_try = 1'b1;
            default: state_d = StIdle;
        endcase

        // A buffered write to the same byte answers the read without touching the BRAM.
        if (rd_try) begin
            rd_active = 1'b1;
            if (wb_hit) begin
                rd_fwd_d      = 1'b1;
                rd_fwd_data_d = wb_data;
                state_d       = StData;
            end else if (!vid_req_i) begin
                rd_fwd_d = 1'b0;
                rd_port  = 1'b1;
                state_d  = StData;
            end else begin
                state_d = StWait;
            end
        end
    end

    assign drain       = wb_valid && !vid_req_i && !rd_active && !reset_i;
    assign cpu_wbusy_o = wb_valid && !drain;
    assign wb_load     = cpu_wstrb_i && !cpu_wbusy_o;
    assign cpu_rbusy_o = (state_q == StWait);
    assign cpu_rdata_o = replicate_byte((state_q == StData) ? rd_byte : cpu_hold_q);

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        if (vid_req_i) begin
            mem_addr_o = vid_addr_i;
        end else if (rd_port) begin
            mem_addr_o = rd_cur_addr;
        end else if (drain) begin
            mem_addr_o  = wb_addr;
            mem_we_o    = 1'b1;
            mem_wdata_o = wb_data;
        end
    end

    // Video data passes straight through the cycle after a request and is held otherwise.
    assign vid_byte    = vid_req_q ? mem_rdata_i : vid_hold_q;
    assign vid_rdata_o = vid_byte;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            rd_addr_q     <= '0;
            rd_fwd_q      <= 1'b0;
            rd_fwd_data_q <= '0;
            cpu_hold_q    <= '0;
            vid_req_q     <= 1'b0;
            vid_hold_q    <= '0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            rd_fwd_q      <= rd_fwd_d;
            rd_fwd_data_q <= rd_fwd_data_d;
            cpu_hold_q    <= cpu_hold_d;
            vid_req_q     <= vid_req_i;
            vid_hold_q    <= vid_byte;
        end
    end

endmodule
